// File: rtl/mac_stream_ctrl_pkg.sv
// Shared constants for the MAC lane: operand/accumulator widths used by both the
// stream controller and the processing element it drives.
package mac_stream_ctrl_pkg;

   localparam int MAC_W      = 16;
   localparam int MAC_ACC_W  = 33;
   localparam int MAC_CNT_W  = 16;
   localparam int MAC_PE_LAT = 1;
   localparam int STATE_W    = 3;

   typedef logic [STATE_W-1:0] ctrl_state_t;

endpackage

// File: rtl/mac_stream_ctrl_if.sv
// Bundles the operand stream, PE drive/return and result stream of one MAC lane.
// Both streams use valid/ready: a beat transfers on a rising clk edge where valid
// and ready are both 1; valid must not depend on ready.
interface mac_stream_ctrl_if
   import mac_stream_ctrl_pkg::*;
#(
   parameter int W     = MAC_W,
   parameter int ACC_W = MAC_ACC_W,
   parameter int CNT_W = MAC_CNT_W
) ();

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic             in_last;

   logic [W-1:0]     pe_a;
   logic [W-1:0]     pe_b;
   logic             pe_en;
   logic             pe_clear;
   logic [ACC_W-1:0] pe_c;

   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;

   logic             busy;
   ctrl_state_t      dbg_state;

   modport slave (
      input  in_valid, in_a, in_b, in_last, pe_c, out_ready,
      output in_ready, pe_a, pe_b, pe_en, pe_clear,
             out_valid, out_data, out_count, busy, dbg_state
   );

   modport master (
      output in_valid, in_a, in_b, in_last, pe_c, out_ready,
      input  in_ready, pe_a, pe_b, pe_en, pe_clear,
             out_valid, out_data, out_count, busy, dbg_state
   );

endinterface

// File: rtl/mac_stream_ctrl.sv
// Sequencer in front of a MAC processing element: clears the PE, streams operand
// pairs into it, waits out the PE latency and holds the result for the consumer.
module mac_stream_ctrl
   import mac_stream_ctrl_pkg::*;
#(
   parameter int W      = MAC_W,
   parameter int ACC_W  = MAC_ACC_W,
   parameter int CNT_W  = MAC_CNT_W,
   parameter int PE_LAT = MAC_PE_LAT
) (
   input  logic clk,
   input  logic rst,
   mac_stream_ctrl_if.slave bus
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;

   localparam int LAT_W = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;

   logic [2:0]       state_q, state_d;
   logic [W-1:0]     pe_a_q, pe_a_d;
   logic [W-1:0]     pe_b_q, pe_b_d;
   logic             pe_en_q, pe_en_d;
   logic             pe_clear_q, pe_clear_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [LAT_W-1:0] lat_q, lat_d;

   logic             in_ready;
   logic             accept;
   logic [CNT_W-1:0] beat_base;
   logic [CNT_W-1:0] beat_inc;

   assign in_ready  = (state_q == ST_CLEAR) || (state_q == ST_STREAM);
   assign accept    = bus.in_valid && in_ready;

   // The CLEAR cycle restarts the count, so a pair taken there is beat one.
   assign beat_base = (state_q == ST_CLEAR) ? '0 : beat_q;
   assign beat_inc  = (beat_base == {CNT_W{1'b1}}) ? beat_base : beat_base + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      pe_a_d      = pe_a_q;
      pe_b_d      = pe_b_q;
      pe_en_d     = 1'b0;
      pe_clear_d  = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      beat_d      = beat_q;
      lat_d       = lat_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_d    = ST_CLEAR;
               pe_clear_d = 1'b1;
            end
         end

         ST_CLEAR, ST_STREAM: begin
            beat_d = beat_base;
            if (state_q == ST_CLEAR) state_d = ST_STREAM;
            if (accept) begin
               pe_a_d  = bus.in_a;
               pe_b_d  = bus.in_b;
               pe_en_d = 1'b1;
               beat_d  = beat_inc;
               if (bus.in_last) begin
                  state_d = ST_DRAIN;
                  lat_d   = LAT_W'(PE_LAT);
               end
            end
         end

         // Last product is issued the cycle after entry; pe_c catches up PE_LAT later.
         ST_DRAIN: begin
            if (lat_q == '0) begin
               out_data_d  = bus.pe_c;
               out_count_d = beat_q;
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end

         ST_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (bus.in_valid) begin
                  state_d    = ST_CLEAR;
                  pe_clear_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pe_a_q      <= '0;
         pe_b_q      <= '0;
         pe_en_q     <= 1'b0;
         pe_clear_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         beat_q      <= '0;
         lat_q       <= '0;
      end else begin
         state_q     <= state_d;
         pe_a_q      <= pe_a_d;
         pe_b_q      <= pe_b_d;
         pe_en_q     <= pe_en_d;
         pe_clear_q  <= pe_clear_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         beat_q      <= beat_d;
         lat_q       <= lat_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.pe_a      = pe_a_q;
   assign bus.pe_b      = pe_b_q;
   assign bus.pe_en     = pe_en_q;
   assign bus.pe_clear  = pe_clear_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_count = out_count_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.dbg_state = ctrl_state_t'(state_q);

   // The PE gives clear priority, so an overlap would silently drop a product.
   clear_en_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(pe_en_q && pe_clear_q));

endmodule
